parity_serial_tx: RTL

- Downstream stage of the parity generator. Takes its (N+1)-bit output word {data, parity} and transmits it on a single serial line, UART-style.
- Frame order: start bit, N data bits LSB first, the parity bit, then STOP_BITS stop bits.
- A valid/ready handshake on the input lets upstream logic stall until the line is free.
- Sits between the parity generator and the board-level TX pin.

---
 rtl/parity_serial_tx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/parity_serial_tx.sv
// parity_serial_tx: UART-style serializer for {data, parity} words.
// Frame is start, data LSB first, parity, then stop bit(s).
module parity_serial_tx #(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N:0]   data_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         tx_out,
  output logic         busy,
  output logic         frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BM = (N > STOP_BITS) ? N : STOP_BITS;
  localparam int BW = $clog2(BM + 1);

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(N - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] baud_cnt, baud_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [N:0]    shreg, shreg_n;
  logic          tx_n;

  logic          last_tick;
  logic          frame_end;
  logic          accept;
  logic [N:0]    word_rot;

  // Parity rotated to the top so it falls out
  // at bit 0 after the N data shifts.
  assign word_rot   = {data_in[0], data_in[N:1]};

  assign last_tick  = (baud_cnt == BAUD_LAST);
  assign frame_end  = (state == STOP) && last_tick
                    && (bit_cnt == STOP_LAST);
  assign in_ready   = (state == IDLE) || frame_end;
  assign accept     = in_valid && in_ready;
  assign busy       = (state != IDLE);
  assign frame_done = frame_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_out   <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
      tx_out   <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    baud_n  = '0;

    if (state != IDLE && !last_tick) begin
      baud_n = baud_cnt + 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = START;
          shreg_n = word_rot;
          bit_n   = '0;
        end
      end
      START: begin
        if (last_tick) begin
          state_n = DATA;
          bit_n   = '0;
        end
      end
      DATA: begin
        if (last_tick) begin
          shreg_n = {1'b0, shreg[N:1]};
          if (bit_cnt == DATA_LAST) begin
            state_n = PARITY;
            bit_n   = '0;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (last_tick) begin
          state_n = STOP;
          bit_n   = '0;
        end
      end
      STOP: begin
        if (last_tick) begin
          if (bit_cnt == STOP_LAST) begin
            bit_n = '0;
            if (accept) begin
              state_n = START;
              shreg_n = word_rot;
            end else begin
              state_n = IDLE;
            end
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        bit_n   = '0;
      end
    endcase
  end

  // Line level is registered from the next state so
  // each bit lines up exactly with its baud window.
  always_comb begin
    tx_n = 1'b1;
    unique case (1'b1)
      (state_n == START):  tx_n = 1'b0;
      (state_n == DATA):   tx_n = shreg_n[0];
      (state_n == PARITY): tx_n = shreg_n[0];
      default:             tx_n = 1'b1;
    endcase
  end

endmodule
